// File: rtl/melody_sequencer.sv
// Multi-melody square-wave tone sequencer for a piezo buzzer pin.
// A trigger selects a melody; each note plays a table-driven half-period for NOTE_CYC cycles.
module melody_sequencer #(
  parameter int NUM_MEL  = 2,
  parameter int NOTES    = 4,
  parameter int HP_W     = 18,
  parameter int DUR_W    = 23,
  parameter int NOTE_CYC = 7_000_000,
  parameter int RETRIG   = 0,
  localparam int MEL_W   = (NUM_MEL > 1) ? $clog2(NUM_MEL) : 1,
  localparam int NI_W    = (NOTES > 1) ? $clog2(NOTES) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [NUM_MEL-1:0]            trig_i,
  input  logic                          abort_i,
  input  logic                          loop_en_i,
  input  logic [NUM_MEL*NOTES*HP_W-1:0] hp_tbl_i,
  output logic                          buzzer_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [MEL_W-1:0]              mel_id_o,
  output logic [NI_W-1:0]               note_idx_o
);

  // state  | meaning
  // S_IDLE | silent, waiting for a trigger
  // S_PLAY | stepping through the notes of mel_id
  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              buzzer_q, buzzer_d;
  logic              done_q, done_d;
  logic [MEL_W-1:0]  mel_id_q, mel_id_d;
  logic [NI_W-1:0]   note_idx_q, note_idx_d;
  logic [HP_W-1:0]   freq_cnt_q, freq_cnt_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;

  logic              any_trig;
  logic [MEL_W-1:0]  trig_idx;
  logic [HP_W-1:0]   hp_cur;
  logic              dur_end;
  logic              note_last;
  logic              freq_hit;
  logic              retrig_hit;

  // Scan downward so the lowest set trigger index is the one left standing.
  always_comb begin
    trig_idx = '0;
    for (int i = NUM_MEL - 1; i >= 0; i--) begin
      if (trig_i[i]) trig_idx = MEL_W'(i);
    end
  end

  assign any_trig   = |trig_i;
  assign hp_cur     = hp_tbl_i[(int'(mel_id_q) * NOTES + int'(note_idx_q)) * HP_W +: HP_W];
  assign dur_end    = (dur_cnt_q == DUR_W'(NOTE_CYC - 1));
  assign note_last  = (note_idx_q == NI_W'(NOTES - 1));
  assign freq_hit   = (freq_cnt_q == hp_cur - HP_W'(1));
  assign retrig_hit = (RETRIG != 0) && any_trig;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      buzzer_q   <= 1'b0;
      done_q     <= 1'b0;
      mel_id_q   <= '0;
      note_idx_q <= '0;
      freq_cnt_q <= '0;
      dur_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      buzzer_q   <= buzzer_d;
      done_q     <= done_d;
      mel_id_q   <= mel_id_d;
      note_idx_q <= note_idx_d;
      freq_cnt_q <= freq_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_trig && !abort_i) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (retrig_hit) begin
          state_d = S_PLAY;
        end else if (dur_end && note_last && !loop_en_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buzzer_d   = buzzer_q;
    done_d     = 1'b0;
    mel_id_d   = mel_id_q;
    note_idx_d = note_idx_q;
    freq_cnt_d = freq_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    case (state_q)
      S_IDLE: begin
        buzzer_d = 1'b0;
        if (any_trig && !abort_i) begin
          mel_id_d   = trig_idx;
          note_idx_d = '0;
          freq_cnt_d = '0;
          dur_cnt_d  = '0;
        end
      end
      S_PLAY: begin
        if (abort_i) begin
          buzzer_d   = 1'b0;
          note_idx_d = '0;
          freq_cnt_d = '0;
          dur_cnt_d  = '0;
        end else if (retrig_hit) begin
          buzzer_d   = 1'b0;
          mel_id_d   = trig_idx;
          note_idx_d = '0;
          freq_cnt_d = '0;
          dur_cnt_d  = '0;
        end else if (dur_end) begin
          // Every note, including a looped note 0, starts from a low buzzer.
          buzzer_d   = 1'b0;
          freq_cnt_d = '0;
          dur_cnt_d  = '0;
          if (!note_last) begin
            note_idx_d = note_idx_q + NI_W'(1);
          end else begin
            note_idx_d = '0;
            done_d     = !loop_en_i;
          end
        end else begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
          if (hp_cur == '0) begin
            buzzer_d   = 1'b0;
            freq_cnt_d = '0;
          end else if (freq_hit) begin
            buzzer_d   = !buzzer_q;
            freq_cnt_d = '0;
          end else begin
            freq_cnt_d = freq_cnt_q + HP_W'(1);
          end
        end
      end
      default: begin
        buzzer_d = 1'b0;
      end
    endcase
  end

  assign buzzer_o   = buzzer_q;
  assign busy_o     = (state_q == S_PLAY);
  assign done_o     = done_q;
  assign mel_id_o   = mel_id_q;
  assign note_idx_o = note_idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: three instances (RETRIG=0, RETRIG=1, NOTE_CYC=1) share stimulus
// and are compared each cycle against a note/time-position model of the melody.
module tb_melody_sequencer;
  localparam int NM  = 2;
  localparam int NN  = 4;
  localparam int HPW = 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] trig = '0;
  logic abort = 1'b0;
  logic loop_en = 1'b0;
  logic [NM*NN*HPW-1:0] tbl_a, tbl_b;

  logic       buz_o  [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       mel_o  [3];
  logic [1:0] ni_o   [3];

  int hp_a [2][4] = '{'{2, 3, 0, 5}, '{1, 1, 1, 1}};
  int nc [3] = '{20, 20, 1};
  int rt [3] = '{0, 1, 0};

  int m_play [3];
  int m_mel  [3];
  int m_note [3];
  int m_t    [3];
  int m_done [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  melody_sequencer #(.NUM_MEL(NM), .NOTES(NN), .HP_W(HPW), .DUR_W(23), .NOTE_CYC(20), .RETRIG(0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .trig_i(trig), .abort_i(abort), .loop_en_i(loop_en),
    .hp_tbl_i(tbl_a), .buzzer_o(buz_o[0]), .busy_o(busy_o[0]), .done_o(done_o[0]),
    .mel_id_o(mel_o[0]), .note_idx_o(ni_o[0]));

  melody_sequencer #(.NUM_MEL(NM), .NOTES(NN), .HP_W(HPW), .DUR_W(23), .NOTE_CYC(20), .RETRIG(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .trig_i(trig), .abort_i(abort), .loop_en_i(loop_en),
    .hp_tbl_i(tbl_a), .buzzer_o(buz_o[1]), .busy_o(busy_o[1]), .done_o(done_o[1]),
    .mel_id_o(mel_o[1]), .note_idx_o(ni_o[1]));

  melody_sequencer #(.NUM_MEL(NM), .NOTES(NN), .HP_W(HPW), .DUR_W(23), .NOTE_CYC(1), .RETRIG(0)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .trig_i(trig), .abort_i(abort), .loop_en_i(loop_en),
    .hp_tbl_i(tbl_b), .buzzer_o(buz_o[2]), .busy_o(busy_o[2]), .done_o(done_o[2]),
    .mel_id_o(mel_o[2]), .note_idx_o(ni_o[2]));

  function automatic int hp_of(int d, int m, int n);
    return (d == 2) ? 1 : hp_a[m][n];
  endfunction

  task automatic chk(input string tag, input int d, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0d expected %0d", tag, d, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_play[d] = 0; m_mel[d] = 0; m_note[d] = 0; m_t[d] = 0; m_done[d] = 0;
    end
  endtask

  // Time position within the note drives the tone: buzzer = floor(t/hp) mod 2.
  task automatic model_step();
    int low;
    low = trig[0] ? 0 : 1;
    for (int d = 0; d < 3; d++) begin
      m_done[d] = 0;
      if (m_play[d] == 0) begin
        if (!abort && trig != 2'b00) begin
          m_play[d] = 1; m_mel[d] = low; m_note[d] = 0; m_t[d] = 0;
        end
      end else if (abort) begin
        m_play[d] = 0; m_note[d] = 0; m_t[d] = 0;
      end else if (rt[d] != 0 && trig != 2'b00) begin
        m_mel[d] = low; m_note[d] = 0; m_t[d] = 0;
      end else begin
        m_t[d]++;
        if (m_t[d] == nc[d]) begin
          m_t[d] = 0;
          if (m_note[d] < NN - 1) m_note[d]++;
          else if (loop_en) m_note[d] = 0;
          else begin
            m_play[d] = 0; m_note[d] = 0; m_done[d] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int hp, eb;
    for (int d = 0; d < 3; d++) begin
      hp = hp_of(d, m_mel[d], m_note[d]);
      eb = (m_play[d] != 0 && hp != 0) ? ((m_t[d] / hp) % 2) : 0;
      chk("buzzer", d, 16'(buz_o[d]), 16'(eb));
      chk("busy", d, 16'(busy_o[d]), 16'(m_play[d]));
      chk("done", d, 16'(done_o[d]), 16'(m_done[d]));
      chk("mel_id", d, 16'(mel_o[d]), 16'(m_mel[d]));
      chk("note_idx", d, 16'(ni_o[d]), 16'(m_note[d]));
    end
  endtask

  task automatic cyc(input logic [1:0] t, input logic a, input logic l);
    trig = t; abort = a; loop_en = l;
    @(posedge clk);
    @(negedge clk);
    model_step();
    check_all();
  endtask

  initial begin
    int busy0, busy2, dones, done_at, wrap, seen;
    logic prev, exp_t;
    logic [1:0] pni;
    logic lp;

    for (int m = 0; m < NM; m++)
      for (int n = 0; n < NN; n++) begin
        tbl_a[(m*NN+n)*HPW +: HPW] = HPW'(hp_a[m][n]);
        tbl_b[(m*NN+n)*HPW +: HPW] = HPW'(1);
      end

    // reset state
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b00, 1'b1, 1'b0);

    // one-shot melody 0
    busy0 = 0; busy2 = 0; dones = 0; done_at = 0;
    cyc(2'b01, 1'b0, 1'b0);
    for (int n = 1; n <= 90; n++) begin
      if (n > 1) cyc(2'b00, 1'b0, 1'b0);
      if (busy_o[0]) busy0++;
      if (busy_o[2]) busy2++;
      if (done_o[0]) begin dones++; done_at = n; end
    end
    chk("busy_len", 0, 16'(busy0), 16'd80);
    chk("busy_len", 2, 16'(busy2), 16'd4);
    chk("done_count", 0, 16'(dones), 16'd1);
    chk("done_cycle", 0, 16'(done_at), 16'd81);

    // both triggers with loop mode
    cyc(2'b11, 1'b0, 1'b1);
    chk("prio_mel", 0, 16'(mel_o[0]), 16'd0);
    wrap = 0; dones = 0;
    for (int n = 0; n < 99; n++) begin
      pni = ni_o[0];
      cyc(2'b00, 1'b0, 1'b1);
      if (pni == 2'd3 && ni_o[0] == 2'd0 && busy_o[0]) wrap = 1;
      if (done_o[0]) dones++;
    end
    chk("loop_wrap", 0, 16'(wrap), 16'd1);
    chk("loop_no_done", 0, 16'(dones), 16'd0);
    seen = 0;
    for (int n = 0; n < 100 && seen == 0; n++) begin
      cyc(2'b00, 1'b0, 1'b0);
      if (done_o[0]) seen = 1;
    end
    chk("loop_end_done", 0, 16'(seen), 16'd1);

    // abort during melody 1
    dones = 0;
    cyc(2'b10, 1'b0, 1'b0);
    for (int n = 0; n < 29; n++) begin
      cyc(2'b00, 1'b0, 1'b0);
      if (done_o[0]) dones++;
    end
    cyc(2'b00, 1'b1, 1'b0);
    chk("abort_busy", 0, 16'(busy_o[0]), 16'd0);
    chk("abort_buz", 0, 16'(buz_o[0]), 16'd0);
    chk("abort_done", 0, 16'(dones + int'(done_o[0])), 16'd0);
    cyc(2'b11, 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) chk("trig_abort_idle", d, 16'(busy_o[d]), 16'd0);

    // trigger while busy
    cyc(2'b01, 1'b0, 1'b0);
    for (int n = 0; n < 9; n++) cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0);
    chk("no_retrig_mel", 0, 16'(mel_o[0]), 16'd0);
    chk("retrig_mel", 1, 16'(mel_o[1]), 16'd1);
    chk("retrig_note", 1, 16'(ni_o[1]), 16'd0);
    for (int n = 0; n < 5; n++) begin
      prev = buz_o[1];
      exp_t = !prev;
      cyc(2'b00, 1'b0, 1'b0);
      chk("retrig_toggle", 1, 16'(buz_o[1]), 16'(exp_t));
    end

    // async reset mid-play
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_buz", d, 16'(buz_o[d]), 16'd0);
      chk("rst_busy", d, 16'(busy_o[d]), 16'd0);
      chk("rst_done", d, 16'(done_o[d]), 16'd0);
      chk("rst_note", d, 16'(ni_o[d]), 16'd0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2'b00, 1'b0, 1'b0);

    // randomized traffic
    lp = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] t;
      logic a;
      t = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 49) == 0) lp = !lp;
      cyc(t, a, lp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
